// File: rtl/keypad_debouncer_if.sv
// Front-panel signal bundle between the raw contacts and the debouncer.
// master: the panel side (drives raw contacts, observes clean levels).
// slave:  the debouncer (reads raw contacts, drives clean levels).
interface keypad_debouncer_if;
    logic [9:0] raw_keys;
    logic       raw_startn;
    logic       raw_stopn;
    logic       raw_clearn;
    logic       raw_door_closed;

    logic [9:0] keys;
    logic       key_strobe;
    logic       key_err;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door_closed;

    modport master (
        output raw_keys, raw_startn, raw_stopn, raw_clearn, raw_door_closed,
        input  keys, key_strobe, key_err, startn, stopn, clearn, door_closed
    );

    modport slave (
        input  raw_keys, raw_startn, raw_stopn, raw_clearn, raw_door_closed,
        output keys, key_strobe, key_err, startn, stopn, clearn, door_closed
    );
endinterface

// File: rtl/keypad_debouncer.sv
// Front-panel input conditioner: synchronises and debounces 14 raw contacts
// (10 digits, start/stop/clear, door) and applies multi-digit lockout so the
// downstream encoder sees at most one digit at a time.
// Channel packing: [9:0] digits, [10] startn, [11] stopn, [12] clearn, [13] door_closed.
module keypad_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic              clock,
    input  logic              resetn,
    keypad_debouncer_if.slave pad
);
    localparam int N_CH = 14;
    // Idle levels: digits released, active-low buttons released, door open.
    localparam logic [N_CH-1:0]  IDLE = {1'b0, 3'b111, 10'b0};
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [N_CH-1:0]  raw;
    logic [N_CH-1:0]  s1;
    logic [N_CH-1:0]  s2;
    logic [N_CH-1:0]  stable;
    logic [CNT_W-1:0] cnt [N_CH];

    logic [9:0] stable_keys;
    logic [9:0] keys_int;
    logic [9:0] key_prev;
    logic       key_multi;
    logic       key_strobe_q;

    assign raw = {pad.raw_door_closed, pad.raw_clearn, pad.raw_stopn,
                  pad.raw_startn, pad.raw_keys};

    // Two-flop synchroniser for every asynchronous contact.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1 <= IDLE;
            s2 <= IDLE;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Per-channel debounce: any disagreement run must last DEBOUNCE_CYCLES
    // uninterrupted cycles before stable follows; a bounce back restarts it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stable <= IDLE;
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (s2[ch] == stable[ch]) begin
                    cnt[ch] <= '0;
                end else if (cnt[ch] == TERM) begin
                    stable[ch] <= s2[ch];
                    cnt[ch]    <= '0;
                end else begin
                    cnt[ch] <= cnt[ch] + ONE;
                end
            end
        end
    end

    // Digit lockout: x & (x-1) is non-zero exactly when two or more bits are set.
    always_comb begin
        stable_keys = stable[9:0];
        key_multi   = |(stable_keys & (stable_keys - 10'd1));
        keys_int    = key_multi ? 10'd0 : stable_keys;
    end

    // Strobe whenever the presented digit changes to a new non-zero value.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            key_prev     <= '0;
            key_strobe_q <= 1'b0;
        end else begin
            key_prev     <= keys_int;
            key_strobe_q <= (keys_int != 10'd0) && (keys_int != key_prev);
        end
    end

    assign pad.keys        = keys_int;
    assign pad.key_err     = key_multi;
    assign pad.key_strobe  = key_strobe_q;
    assign pad.startn      = stable[10];
    assign pad.stopn       = stable[11];
    assign pad.clearn      = stable[12];
    assign pad.door_closed = stable[13];
endmodule

// File: tb/tb_keypad_debouncer.sv
// Testbench for keypad_debouncer with DEBOUNCE_CYCLES=4: directed scenarios
// with fixed expected timing plus a randomized run against a window-based model.
module tb_keypad_debouncer;
    localparam int D  = 4;
    localparam int CW = 3;
    localparam logic [13:0] IDLE = {1'b0, 3'b111, 10'b0};

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    keypad_debouncer_if ifc();

    keypad_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
        .clock  (clock),
        .resetn (resetn),
        .pad    (ifc.slave)
    );

    always #5 clock = ~clock;

    // Reference model: a channel takes the synchronised level once the last D
    // synchronised samples all agree and differ from the current stable level.
    logic [13:0] m_hist [0:D];
    logic [13:0] m_stable;
    logic [9:0]  m_keys_prev;
    logic        m_strobe;

    function automatic logic [9:0] m_keys_of(input logic [13:0] st);
        return ($countones(st[9:0]) == 1) ? st[9:0] : 10'd0;
    endfunction

    function automatic logic m_err_of(input logic [13:0] st);
        return $countones(st[9:0]) >= 2;
    endfunction

    task automatic model_step();
        logic [9:0] kb;
        logic       same;
        if (!resetn) begin
            for (int k = 0; k <= D; k++) m_hist[k] = IDLE;
            m_stable    = IDLE;
            m_keys_prev = '0;
            m_strobe    = 1'b0;
        end else begin
            kb          = m_keys_of(m_stable);
            m_strobe    = (kb != 10'd0) && (kb != m_keys_prev);
            m_keys_prev = kb;
            for (int ch = 0; ch < 14; ch++) begin
                same = 1'b1;
                for (int k = 2; k <= D; k++)
                    if (m_hist[k][ch] != m_hist[1][ch]) same = 1'b0;
                if (same) m_stable[ch] = m_hist[1][ch];
            end
            for (int k = D; k >= 1; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = {ifc.raw_door_closed, ifc.raw_clearn, ifc.raw_stopn,
                         ifc.raw_startn, ifc.raw_keys};
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge resetn);
            model_step();
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic test_reset();
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks += 7;
            if (ifc.keys !== 10'd0) begin errors++; $display("FAIL reset_keys: got %h expected 000", ifc.keys); end
            if (ifc.key_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", ifc.key_strobe); end
            if (ifc.key_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", ifc.key_err); end
            if (ifc.startn !== 1'b1) begin errors++; $display("FAIL reset_startn: got %b expected 1", ifc.startn); end
            if (ifc.stopn !== 1'b1) begin errors++; $display("FAIL reset_stopn: got %b expected 1", ifc.stopn); end
            if (ifc.clearn !== 1'b1) begin errors++; $display("FAIL reset_clearn: got %b expected 1", ifc.clearn); end
            if (ifc.door_closed !== 1'b0) begin errors++; $display("FAIL reset_door: got %b expected 0", ifc.door_closed); end
        end
        resetn = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_clean_press();
        logic [9:0] exp_k;
        ifc.raw_keys = 10'h008;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clock);
            exp_k = (i >= 5) ? 10'h008 : 10'h000;
            checks += 2;
            if (ifc.keys !== exp_k) begin errors++; $display("FAIL press_keys edge+%0d: got %h expected %h", i, ifc.keys, exp_k); end
            if (ifc.key_strobe !== (i == 6)) begin errors++; $display("FAIL press_strobe edge+%0d: got %b expected %b", i, ifc.key_strobe, (i == 6)); end
        end
        ifc.raw_keys = 10'h000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if (ifc.key_strobe !== 1'b0) begin errors++; $display("FAIL release_strobe cycle %0d: got %b expected 0", i, ifc.key_strobe); end
        end
        checks++;
        if (ifc.keys !== 10'd0) begin errors++; $display("FAIL release_keys: got %h expected 000", ifc.keys); end
    endtask

    task automatic test_bounce();
        for (int b = 0; b < 4; b++) begin
            ifc.raw_startn = b[0];
            repeat (2) begin
                @(negedge clock);
                checks++;
                if (ifc.startn !== 1'b1) begin errors++; $display("FAIL bounce_hold phase %0d: got %b expected 1", b, ifc.startn); end
            end
        end
        ifc.raw_startn = 1'b0;
        for (int i = 0; i <= 7; i++) begin
            @(negedge clock);
            checks++;
            if (ifc.startn !== (i < 5)) begin errors++; $display("FAIL bounce_settle edge+%0d: got %b expected %b", i, ifc.startn, (i < 5)); end
        end
        ifc.raw_startn = 1'b1;
        repeat (10) @(negedge clock);
        checks++;
        if (ifc.startn !== 1'b1) begin errors++; $display("FAIL bounce_release: got %b expected 1", ifc.startn); end
    endtask

    task automatic test_multi_key();
        ifc.raw_keys = 10'h024;
        for (int i = 0; i <= 7; i++) begin
            @(negedge clock);
            checks += 3;
            if (ifc.keys !== 10'd0) begin errors++; $display("FAIL multi_keys edge+%0d: got %h expected 000", i, ifc.keys); end
            if (ifc.key_err !== (i >= 5)) begin errors++; $display("FAIL multi_err edge+%0d: got %b expected %b", i, ifc.key_err, (i >= 5)); end
            if (ifc.key_strobe !== 1'b0) begin errors++; $display("FAIL multi_strobe edge+%0d: got %b expected 0", i, ifc.key_strobe); end
        end
        ifc.raw_keys = 10'h004;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clock);
            checks += 3;
            if (ifc.keys !== ((i >= 5) ? 10'h004 : 10'h000)) begin errors++; $display("FAIL unlock_keys edge+%0d: got %h expected %h", i, ifc.keys, ((i >= 5) ? 10'h004 : 10'h000)); end
            if (ifc.key_err !== (i < 5)) begin errors++; $display("FAIL unlock_err edge+%0d: got %b expected %b", i, ifc.key_err, (i < 5)); end
            if (ifc.key_strobe !== (i == 6)) begin errors++; $display("FAIL unlock_strobe edge+%0d: got %b expected %b", i, ifc.key_strobe, (i == 6)); end
        end
        ifc.raw_keys = 10'h000;
        repeat (10) @(negedge clock);
        checks += 2;
        if (ifc.keys !== 10'd0) begin errors++; $display("FAIL multi_release_keys: got %h expected 000", ifc.keys); end
        if (ifc.key_err !== 1'b0) begin errors++; $display("FAIL multi_release_err: got %b expected 0", ifc.key_err); end
    endtask

    task automatic test_door();
        ifc.raw_door_closed = 1'b1;
        @(negedge clock);
        ifc.raw_door_closed = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if (ifc.door_closed !== 1'b0) begin errors++; $display("FAIL door_glitch cycle %0d: got %b expected 0", i, ifc.door_closed); end
        end
        ifc.raw_door_closed = 1'b1;
        for (int i = 0; i <= 7; i++) begin
            @(negedge clock);
            checks++;
            if (ifc.door_closed !== (i >= 5)) begin errors++; $display("FAIL door_close edge+%0d: got %b expected %b", i, ifc.door_closed, (i >= 5)); end
        end
        ifc.raw_door_closed = 1'b0;
        repeat (10) @(negedge clock);
        checks++;
        if (ifc.door_closed !== 1'b0) begin errors++; $display("FAIL door_open: got %b expected 0", ifc.door_closed); end
    endtask

    task automatic test_reset_mid_count();
        ifc.raw_clearn = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            checks++;
            if (ifc.clearn !== 1'b1) begin errors++; $display("FAIL midrst_in_reset cycle %0d: got %b expected 1", i, ifc.clearn); end
        end
        resetn = 1'b1;
        for (int i = 0; i <= 7; i++) begin
            @(negedge clock);
            checks++;
            if (ifc.clearn !== (i < 5)) begin errors++; $display("FAIL midrst_settle edge+%0d: got %b expected %b", i, ifc.clearn, (i < 5)); end
        end
        ifc.raw_clearn = 1'b1;
        repeat (10) @(negedge clock);
        checks++;
        if (ifc.clearn !== 1'b1) begin errors++; $display("FAIL midrst_release: got %b expected 1", ifc.clearn); end
    endtask

    task automatic test_random();
        int rst_left = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clock);
            checks += 7;
            if (ifc.keys !== m_keys_of(m_stable)) begin errors++; $display("FAIL rand_keys cycle %0d: got %h expected %h", cyc, ifc.keys, m_keys_of(m_stable)); end
            if (ifc.key_err !== m_err_of(m_stable)) begin errors++; $display("FAIL rand_err cycle %0d: got %b expected %b", cyc, ifc.key_err, m_err_of(m_stable)); end
            if (ifc.key_strobe !== m_strobe) begin errors++; $display("FAIL rand_strobe cycle %0d: got %b expected %b", cyc, ifc.key_strobe, m_strobe); end
            if (ifc.startn !== m_stable[10]) begin errors++; $display("FAIL rand_startn cycle %0d: got %b expected %b", cyc, ifc.startn, m_stable[10]); end
            if (ifc.stopn !== m_stable[11]) begin errors++; $display("FAIL rand_stopn cycle %0d: got %b expected %b", cyc, ifc.stopn, m_stable[11]); end
            if (ifc.clearn !== m_stable[12]) begin errors++; $display("FAIL rand_clearn cycle %0d: got %b expected %b", cyc, ifc.clearn, m_stable[12]); end
            if (ifc.door_closed !== m_stable[13]) begin errors++; $display("FAIL rand_door cycle %0d: got %b expected %b", cyc, ifc.door_closed, m_stable[13]); end

            for (int k = 0; k < 10; k++)
                if ($urandom_range(0, 49) == 0) ifc.raw_keys[k] = ~ifc.raw_keys[k];
            if ($urandom_range(0, 9) == 0) ifc.raw_startn      = ~ifc.raw_startn;
            if ($urandom_range(0, 9) == 0) ifc.raw_stopn       = ~ifc.raw_stopn;
            if ($urandom_range(0, 9) == 0) ifc.raw_clearn      = ~ifc.raw_clearn;
            if ($urandom_range(0, 9) == 0) ifc.raw_door_closed = ~ifc.raw_door_closed;

            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) resetn = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                resetn   = 1'b0;
                rst_left = $urandom_range(1, 3);
            end
        end
        resetn = 1'b1;
    endtask

    initial begin
        ifc.raw_keys        = 10'd0;
        ifc.raw_startn      = 1'b1;
        ifc.raw_stopn       = 1'b1;
        ifc.raw_clearn      = 1'b1;
        ifc.raw_door_closed = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi_key();
        test_door();
        test_reset_mid_count();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
